// File: rtl/dist_mem.sv
// -----------------------------------------------------------------------------
// dist_mem
//
// Small distributed (LUT-style) RAM used as a scratch / register-file store in
// the lab datapath. One synchronous write port and one combinational read port
// share a single address. An asynchronous active-low reset clears every word.
//
// Parameters:
//   ADDR_WIDTH : address width; depth is 2**ADDR_WIDTH words
//   DATA_WIDTH : word width in bits
//
// Ports:
//   clk   : clock; writes happen on its rising edge
//   rst_n : asynchronous active-low clear of all words (writes ignored while low)
//   we    : write enable, sampled on the rising clk edge
//   a     : shared write/read address
//   d     : write data
//   spo   : combinational read of the word at a (zero-cycle latency)
// -----------------------------------------------------------------------------
module dist_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] spo
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Next-state of the storage array: only the addressed word can change.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        mem_d = mem_q;
        if (we) begin
            mem_d[a] = d;
        end
    end

    // The clear must act on every word at once and independently of clk, so
    // the array lives in ordinary flops rather than a clocked RAM primitive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this memory is reset on purpose (the block promises an
            // all-zero state); most RAMs are not reset and should not be.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples its input from before the edge.
            mem_q <= mem_d;
        end
    end

    // Asynchronous read: follows a immediately and shows a freshly written
    // word right after the writing edge.
    assign spo = mem_q[a];

endmodule

// File: tb/tb_dist_mem.sv
// -----------------------------------------------------------------------------
// tb_dist_mem
//
// Directed self-checking bench for dist_mem (16 x 8). Inputs change on the
// falling clk edge and outputs are sampled 1 time unit after any change or
// rising edge, so nothing is sampled on the active edge. A small shadow array
// holds the contents the bench has written, used for full-array sweeps.
// -----------------------------------------------------------------------------
module tb_dist_mem;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] spo;

    logic [DW-1:0] model [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    dist_mem #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .a    (a),
        .d    (d),
        .spo  (spo)
    );

    // Period 10: rising edges at 5, 15, 25, ...; falling edges at 10, 20, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a write at the falling edge and hold it for 'cycles' rising edges.
    task automatic write_word(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input int cycles);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        d  = data;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        model[addr] = data;
    endtask

    // Combinational read: change a and sample shortly after, no edge involved.
    task automatic read_check(input string tag, input logic [AW-1:0] addr,
                              input logic [DW-1:0] exp);
        a = addr;
        #1;
        check(tag, spo, exp);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            read_check($sformatf("%s[%0d]", tag, i), AW'(i), model[i]);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        we    = 1'b0;
        a     = '0;
        d     = '0;

        // ---- Reset clear: pulse not aligned to any clk edge ----
        #12;
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        check("reset_active_a0", spo, 8'h00);
        a = 4'd9;
        #1;
        check("reset_active_a9", spo, 8'h00);
        #5;                      // t=19, between edges
        rst_n = 1'b1;
        @(negedge clk);
        sweep("reset_clear");

        // ---- Basic write/read, each write held 2 cycles ----
        write_word(4'd0, 8'h00, 2);
        write_word(4'd1, 8'h01, 2);
        write_word(4'd2, 8'h02, 2);
        read_check("basic_a0", 4'd0, 8'h00);
        read_check("basic_a1", 4'd1, 8'h01);
        read_check("basic_a2", 4'd2, 8'h02);
        read_check("basic_a1_again", 4'd1, 8'h01);

        // ---- Boundary / pattern words ----
        write_word(4'd15, 8'hA5, 1);
        write_word(4'd14, 8'h5A, 1);
        write_word(4'd7,  8'hFF, 1);
        read_check("bound_a15", 4'd15, 8'hA5);
        read_check("bound_a14", 4'd14, 8'h5A);
        read_check("bound_a7",  4'd7,  8'hFF);
        sweep("pattern");

        // ---- Last write wins on back-to-back writes to one address ----
        @(negedge clk);
        we = 1'b1;
        a  = 4'd3;
        d  = 8'hEE;
        @(posedge clk);
        #1;
        check("b2b_first", spo, 8'hEE);
        @(negedge clk);
        d = 8'h11;
        @(posedge clk);
        #1;
        check("b2b_last", spo, 8'h11);
        @(negedge clk);
        we = 1'b0;
        model[3] = 8'h11;

        // ---- Read-during-write at a=3 (holds 8'h11) ----
        @(negedge clk);
        a  = 4'd3;
        we = 1'b1;
        d  = 8'h22;
        #1;
        check("rdw_before_edge", spo, 8'h11);
        @(posedge clk);
        #1;
        check("rdw_after_edge", spo, 8'h22);
        @(negedge clk);
        we = 1'b0;
        model[3] = 8'h22;

        // ---- we=0 guard ----
        write_word(4'd4, 8'h33, 1);
        @(negedge clk);
        a  = 4'd4;
        d  = 8'hCC;
        we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("we0_guard_a4", spo, 8'h33);
        sweep("we0_guard");

        // ---- Reset mid-operation ----
        write_word(4'd5, 8'h44, 1);
        read_check("mid_setup_a5", 4'd5, 8'h44);
        @(negedge clk);
        a  = 4'd5;
        we = 1'b1;
        d  = 8'h99;
        #2;                      // 3 units before the next rising edge
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        check("mid_reset_immediate", spo, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("mid_reset_edges_ignored", spo, 8'h00);
        @(negedge clk);
        we = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_release_a5", spo, 8'h00);
        sweep("mid_reset");
        write_word(4'd5, 8'h77, 1);
        read_check("mid_post_write_a5", 4'd5, 8'h77);
        read_check("mid_post_write_a3", 4'd3, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
